// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetched {pc, instr} pairs with a synchronous clear.
module fetch_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !(rst || clr_i)) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: issues one outstanding imem request per PC, queues responses for decode,
// and flushes queued and in-flight fetches on redirect.
module ifetch_queue #(
    parameter int unsigned XLEN  = ifetch_pkg::XLEN,
    parameter int unsigned DEPTH = 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_we,
    input  logic            redirect,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    import ifetch_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [2*XLEN-1:0] fifo_head;
    logic              push, pop;

    assign imem_req  = (state_q == IDLE) && (fifo_count < CNT_W'(DEPTH)) && !redirect && !rst;
    assign imem_addr = pc;
    assign pc_we     = !rst && ((imem_req && imem_gnt) || redirect);
    assign id_valid  = (fifo_count != '0) && !redirect && !rst;
    assign pop       = id_valid && id_ready;
    assign push      = (state_q == WAIT) && imem_rvalid && !redirect && !rst;
    assign id_pc     = fifo_head[2*XLEN-1:XLEN];
    assign id_instr  = id_valid ? fifo_head[XLEN-1:0] : XLEN'(NOP_INSTR);

    // A response ends every outstanding fetch; redirect only decides whether it is kept.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            IDLE: begin
                if (imem_req && imem_gnt) begin
                    state_d  = WAIT;
                    req_pc_d = pc;
                end
            end
            WAIT: begin
                if (imem_rvalid)   state_d = IDLE;
                else if (redirect) state_d = DROP;
            end
            DROP: begin
                if (imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({req_pc_q, imem_rdata}),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        pc_we;
    logic        redirect = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int checks = 0;
    int errors = 0;
    logic [31:0] target = '0;

    // Memory side: one pending granted address.
    bit          env_pend = 1'b0;
    logic [31:0] env_addr = '0;

    // Reference model: ordered list of kept fetches plus one in-flight slot.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    bit          m_busy = 1'b0;
    bit          m_drop = 1'b0;
    logic [31:0] m_pc = '0;

    always #5 clk = ~clk;

    ifetch_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_we(pc_we), .redirect(redirect),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ NOP_INSTR;
    endfunction

    function automatic bit exp_req();
        return !rst && !redirect && !m_busy && (mq.size() < DEPTH);
    endfunction

    function automatic bit exp_valid();
        return !rst && !redirect && (mq.size() != 0);
    endfunction

    function automatic bit exp_we();
        return !rst && ((exp_req() && imem_gnt) || redirect);
    endfunction

    // Advance one clock, then update model, PC register and memory side.
    task automatic tick();
        bit s_req, s_we, er, ev, push, pop;
        logic [31:0] s_addr;
        s_req = imem_req; s_we = pc_we; s_addr = imem_addr;
        er = exp_req(); ev = exp_valid();
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete(); m_busy = 1'b0; m_drop = 1'b0;
        end else begin
            push = m_busy && !m_drop && imem_rvalid && !redirect;
            pop  = ev && id_ready;
            if (redirect) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back('{m_pc, instr_of(m_pc)});
            end
            if (m_busy && imem_rvalid) begin m_busy = 1'b0; m_drop = 1'b0; end
            else if (m_busy && redirect) m_drop = 1'b1;
            else if (!m_busy && er && imem_gnt) begin m_busy = 1'b1; m_pc = pc; end
        end
        if (imem_rvalid) env_pend = 1'b0;
        if (s_req && imem_gnt) begin env_pend = 1'b1; env_addr = s_addr; end
        if (s_we) pc = redirect ? target : pc + 32'd4;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0; env_pend = 1'b0; pc = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
        checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL reset_pc_we got %b want 0", pc_we); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", id_valid); end
        tick();
        tick();
        rst = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; env_pend = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %b want 1", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", id_valid); end
        checks++; if (dut.fifo_count !== 2'd0) begin errors++; $display("FAIL post_reset_count got %0d want 0", dut.fifo_count); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL post_reset_state got %0d want IDLE", dut.state_q); end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int grants, wes;
        do_reset();
        imem_gnt = 1'b1; id_ready = 1'b1; exp_pc = '0; grants = 0; wes = 0;
        repeat (24) begin
            imem_rvalid = env_pend; imem_rdata = instr_of(env_addr);
            @(negedge clk);
            if (imem_req && imem_gnt) grants++;
            if (pc_we) wes++;
            if (id_valid && id_ready) begin
                checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL stream_pc got %h want %h", id_pc, exp_pc); end
                checks++; if (id_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL stream_instr got %h want %h", id_instr, instr_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        checks++; if (wes != grants) begin errors++; $display("FAIL stream_pc_we got %0d want %0d", wes, grants); end
        checks++; if (exp_pc < 32'd40) begin errors++; $display("FAIL stream_pops got %0d want >=10", exp_pc / 4); end
        imem_rvalid = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        imem_gnt = 1'b1; id_ready = 1'b0;
        repeat (4) begin
            imem_rvalid = env_pend; imem_rdata = instr_of(env_addr);
            @(negedge clk);
            tick();
        end
        imem_rvalid = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req got %b want 0", imem_req); end
        checks++; if (dut.fifo_count !== 2'd2) begin errors++; $display("FAIL full_count got %0d want 2", dut.fifo_count); end
        checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL full_pc_we got %b want 0", pc_we); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL full_head got %h want 0", id_pc); end
        tick();
        id_ready = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL full_rereq got %b want 1", imem_req); end
        checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL full_next_head got %h want 4", id_pc); end
        tick();
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_gnt = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        tick();
        redirect = 1'b1; target = 32'h100;
        @(negedge clk);
        checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL rdw_pc_we got %b want 1", pc_we); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req got %b want 0", imem_req); end
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = (i == 2); imem_rdata = instr_of(env_addr);
            @(negedge clk);
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_drop_req got %b want 0", imem_req); end
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rdw_drop_valid got %b want 0", id_valid); end
            tick();
        end
        imem_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL rdw_new_req got %b/%h want 1/100", imem_req, imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rdw_no_valid got %b want 0", id_valid); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = instr_of(32'h100);
        @(negedge clk);
        tick();
        imem_rvalid = 1'b0; imem_gnt = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errors++; $display("FAIL rdw_target got %b/%h want 1/100", id_valid, id_pc); end
        checks++; if (id_instr !== instr_of(32'h100)) begin errors++; $display("FAIL rdw_instr got %h want %h", id_instr, instr_of(32'h100)); end
        tick();
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        imem_gnt = 1'b1; id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = (i == 1); imem_rdata = instr_of(env_addr);
            @(negedge clk);
            tick();
        end
        redirect = 1'b1; target = 32'h200; imem_rvalid = 1'b1; imem_rdata = instr_of(env_addr);
        @(negedge clk);
        checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL rdr_pc_we got %b want 1", pc_we); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdr_req got %b want 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rdr_valid got %b want 0", id_valid); end
        tick();
        redirect = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
        @(negedge clk);
        checks++; if (dut.fifo_count !== 2'd0) begin errors++; $display("FAIL rdr_count got %0d want 0", dut.fifo_count); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rdr_empty got %b want 0", id_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rdr_new_req got %b/%h want 1/200", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_gnt_stall();
        do_reset();
        pc = 32'h40; imem_gnt = 1'b0; id_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL stall_req got %b/%h want 1/40", imem_req, imem_addr); end
            checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL stall_pc_we got %b want 0", pc_we); end
            tick();
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL stall_grant_we got %b want 1", pc_we); end
        tick();
    endtask

    task automatic test_reset_wait();
        do_reset();
        imem_gnt = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b1; imem_gnt = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rstw_req got %b want 0", imem_req); end
        tick();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h0);
        @(negedge clk);
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rstw_state got %0d want IDLE", dut.state_q); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rstw_idle_req got %b want 1", imem_req); end
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rstw_valid got %b want 0", id_valid); end
        checks++; if (dut.fifo_count !== 2'd0) begin errors++; $display("FAIL rstw_count got %0d want 0", dut.fifo_count); end
        tick();
    endtask

    task automatic drive_random();
        rst         = ($urandom_range(0, 99) == 0);
        redirect    = ($urandom_range(0, 9) == 0);
        target      = $urandom & 32'hFFFF_FFFC;
        imem_gnt    = ($urandom_range(0, 3) != 0);
        imem_rvalid = env_pend && ($urandom_range(0, 2) != 0);
        imem_rdata  = imem_rvalid ? instr_of(env_addr) : $urandom;
        id_ready    = ($urandom_range(0, 1) == 1);
    endtask

    task automatic test_random();
        do_reset();
        repeat (600) begin
            drive_random();
            @(negedge clk);
            checks++; if (imem_req !== exp_req()) begin errors++; $display("FAIL rnd_req got %b want %b", imem_req, exp_req()); end
            checks++; if (pc_we !== exp_we()) begin errors++; $display("FAIL rnd_pc_we got %b want %b", pc_we, exp_we()); end
            checks++; if (id_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid got %b want %b", id_valid, exp_valid()); end
            checks++; if (imem_addr !== pc) begin errors++; $display("FAIL rnd_addr got %h want %h", imem_addr, pc); end
            if (exp_valid()) begin
                checks++; if (id_pc !== mq[0].pc) begin errors++; $display("FAIL rnd_id_pc got %h want %h", id_pc, mq[0].pc); end
                checks++; if (id_instr !== mq[0].instr) begin errors++; $display("FAIL rnd_id_instr got %h want %h", id_instr, mq[0].instr); end
            end
            tick();
        end
        rst = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_rvalid();
        test_gnt_stall();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
